// File: rtl/sort_sequencer.sv
// sort_sequencer - in-place ascending bubble sort of signed 64-bit words over a shared data-memory port.
// Read data is combinational from mem_addr, so the address is valid in the same cycle it is used.
module sort_sequencer #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [63:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              mem_we,
  output logic              port_sel,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  swap_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_CMP  = 3'd3;
  localparam logic [2:0] S_WR_A = 3'd4;
  localparam logic [2:0] S_WR_B = 3'd5;
  localparam logic [2:0] S_NEXT = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  j_q, j_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic [63:0]       a_q, a_d;
  logic [63:0]       b_q, b_d;
  logic              swapped_q, swapped_d;
  logic [CNT_W-1:0]  swap_count_q, swap_count_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;

  // One extra bit so j+1 never wraps even at the maximum count.
  logic [CNT_W:0]    j_ext, jp1;
  logic [ADDR_W-1:0] addr_j, addr_j1;

  always_comb begin
    j_ext   = {1'b0, j_q};
    jp1     = j_ext + 1'b1;
    addr_j  = base_q + (ADDR_W'(j_ext) << 3);
    addr_j1 = base_q + (ADDR_W'(jp1) << 3);
  end

  always_comb begin
    state_d      = state_q;
    j_d          = j_q;
    limit_d      = limit_q;
    a_d          = a_q;
    b_d          = b_q;
    swapped_d    = swapped_q;
    swap_count_d = swap_count_q;
    base_d       = base_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d       = base_addr;
          swap_count_d = '0;
          if (count < CNT_W'(2)) begin
            state_d = S_DONE;
          end else begin
            j_d       = '0;
            limit_d   = count - CNT_W'(1);
            swapped_d = 1'b0;
            state_d   = S_RD_A;
          end
        end
      end
      S_RD_A: begin
        mem_addr_d = addr_j;
        a_d        = mem_rdata;
        state_d    = S_RD_B;
      end
      S_RD_B: begin
        mem_addr_d = addr_j1;
        b_d        = mem_rdata;
        state_d    = S_CMP;
      end
      S_CMP: begin
        // Strict compare keeps equal keys in their original order.
        if ($signed(a_q) > $signed(b_q)) begin
          swapped_d    = 1'b1;
          swap_count_d = swap_count_q + CNT_W'(1);
          state_d      = S_WR_A;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WR_A: begin
        mem_addr_d  = addr_j;
        mem_wdata_d = b_q;
        mem_we      = 1'b1;
        state_d     = S_WR_B;
      end
      S_WR_B: begin
        mem_addr_d  = addr_j1;
        mem_wdata_d = a_q;
        mem_we      = 1'b1;
        state_d     = S_NEXT;
      end
      S_NEXT: begin
        if (jp1 < {1'b0, limit_q}) begin
          j_d     = jp1[CNT_W-1:0];
          state_d = S_RD_A;
        end else if (!swapped_q || limit_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          limit_d   = limit_q - CNT_W'(1);
          j_d       = '0;
          swapped_d = 1'b0;
          state_d   = S_RD_A;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      j_q          <= '0;
      limit_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      swapped_q    <= 1'b0;
      swap_count_q <= '0;
      base_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      j_q          <= j_d;
      limit_q      <= limit_d;
      a_q          <= a_d;
      b_q          <= b_d;
      swapped_q    <= swapped_d;
      swap_count_q <= swap_count_d;
      base_q       <= base_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_addr   = mem_addr_d;
  assign mem_wdata  = mem_wdata_d;
  assign busy       = (state_q != S_IDLE);
  assign port_sel   = busy;
  assign done       = (state_q == S_DONE);
  assign swap_count = swap_count_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// tb/tb_sort_sequencer.sv - scoreboard bench for sort_sequencer with a behavioural data memory.
module tb_sort_sequencer;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 64;
  localparam logic [ADDR_W-1:0] BASE = 64'h1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = BASE;
  logic [CNT_W-1:0]  count = '0;
  logic [63:0]       mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_we, port_sel, busy, done;
  logic [CNT_W-1:0]  swap_count;

  logic [63:0] mem [0:15];
  logic [63:0] init_vals [0:15];
  logic        load_en = 1'b0;
  logic [3:0]  load_idx = '0;
  logic [63:0] load_val = '0;

  int checks = 0, failures = 0;
  int we_total = 0, done_total = 0, psel_bad = 0;
  logic [63:0] exp_mem_q[$];
  int          exp_sw_q[$];

  sort_sequencer #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .port_sel(port_sel), .busy(busy), .done(done), .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[6:3]];

  always @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_val;
    else if (mem_we === 1'b1) mem[mem_addr[6:3]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1) we_total++;
    if (done === 1'b1) done_total++;
    if (port_sel !== busy) psel_bad++;
  end

  task automatic load_mem(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      load_en = 1'b1; load_idx = 4'(k); load_val = init_vals[k];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Reference: sorted copy plus inversion count (bubble sort swaps = inversions).
  task automatic push_expected(input int n);
    logic [63:0] v [0:15];
    logic [63:0] key;
    int inv = 0;
    int p;
    for (int i = 0; i < 16; i++) v[i] = init_vals[i];
    for (int i = 0; i < n; i++)
      for (int k = i + 1; k < n; k++)
        if ($signed(v[i]) > $signed(v[k])) inv++;
    for (int i = 1; i < n; i++) begin
      key = v[i];
      p = i - 1;
      while (p >= 0 && $signed(v[p]) > $signed(key)) begin
        v[p+1] = v[p];
        p--;
      end
      v[p+1] = key;
    end
    for (int i = 0; i < n; i++) exp_mem_q.push_back(v[i]);
    exp_sw_q.push_back(inv);
  endtask

  task automatic run_sort(input string name, input int n, input int exp_lat,
                          input int exp_we, input bit mid_start);
    int cyc, we0, d0, p0, sw;
    logic [63:0] want;
    load_mem(n);
    push_expected(n);
    we0 = we_total; d0 = done_total; p0 = psel_bad;
    @(negedge clk);
    count = CNT_W'(n);
    start = 1'b1;
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (mid_start && cyc == 4) start = 1'b1;
      if (mid_start && cyc == 5) start = 1'b0;
      if (done === 1'b1) break;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s done_timeout: done=%b after %0d cycles, required 1", name, done, cyc);
    end else if (exp_lat >= 0) begin
      checks++;
      if (cyc + 1 != exp_lat) begin
        failures++;
        $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc + 1, exp_lat);
      end
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (done_total - d0 != 1) begin
      failures++;
      $display("FAIL %s done_pulses: got %0d, required 1", name, done_total - d0);
    end
    sw = exp_sw_q.pop_front();
    checks++;
    if (swap_count !== CNT_W'(sw)) begin
      failures++;
      $display("FAIL %s swap_count: got %0d, required %0d", name, swap_count, sw);
    end
    for (int k = 0; k < n; k++) begin
      want = exp_mem_q.pop_front();
      checks++;
      if (mem[k] !== want) begin
        failures++;
        $display("FAIL %s mem[%0d]: got %h, required %h", name, k, mem[k], want);
      end
    end
    if (exp_we >= 0) begin
      checks++;
      if (we_total - we0 != exp_we) begin
        failures++;
        $display("FAIL %s mem_we_cycles: got %0d, required %0d", name, we_total - we0, exp_we);
      end
    end
    checks++;
    if (psel_bad != p0) begin
      failures++;
      $display("FAIL %s port_sel_vs_busy: got %0d mismatching cycles, required 0", name, psel_bad - p0);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({mem_we, port_sel, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL %s ctrl: got we/psel/busy/done=%b, required 0000", name, {mem_we, port_sel, busy, done});
    end
    checks++;
    if (swap_count !== '0) begin
      failures++;
      $display("FAIL %s swap_count: got %0d, required 0", name, swap_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_hold");
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_hold addr_wdata: got %h/%h, required 0/0", mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("reset_release");
  endtask

  task automatic test_basic();
    init_vals[0] = 64'd5; init_vals[1] = -64'sd3; init_vals[2] = 64'd9; init_vals[3] = 64'd0;
    run_sort("basic4", 4, -1, 6, 1'b0);
    checks++;
    if (swap_count !== CNT_W'(3)) begin
      failures++;
      $display("FAIL basic4 swap_const: got %0d, required 3", swap_count);
    end
  endtask

  task automatic test_sorted();
    init_vals[0] = 64'd1; init_vals[1] = 64'd2; init_vals[2] = 64'd3;
    run_sort("sorted3", 3, 10, 0, 1'b0);
  endtask

  task automatic test_short_counts();
    init_vals[0] = 64'd42;
    run_sort("count1", 1, 2, 0, 1'b0);
    run_sort("count0", 0, 2, 0, 1'b0);
  endtask

  task automatic test_signed_boundary();
    init_vals[0] = 64'h7FFF_FFFF_FFFF_FFFF;
    init_vals[1] = 64'h8000_0000_0000_0000;
    init_vals[2] = 64'h0;
    run_sort("signed_bound", 3, -1, -1, 1'b0);
  endtask

  task automatic test_equal_keys_restart();
    init_vals[0] = 64'd2; init_vals[1] = 64'd2; init_vals[2] = 64'd1;
    run_sort("equal_keys", 3, -1, 4, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) init_vals[k] = 64'($signed(32'($urandom_range(0, 8)) - 32'sd4));
      run_sort("random8", 8, -1, -1, 1'b0);
    end
  endtask

  task automatic test_reset_midsort();
    int cyc;
    init_vals[0] = 64'd5; init_vals[1] = -64'sd3; init_vals[2] = 64'd9; init_vals[3] = 64'd0;
    load_mem(4);
    @(negedge clk);
    count = CNT_W'(4);
    start = 1'b1;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (mem_we === 1'b1) break;
    end
    checks++;
    if (mem_we !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid reach_wr_a: mem_we=%b, required 1", mem_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, busy, port_sel, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid async_drop: got we/busy/psel/done=%b, required 0000", {mem_we, busy, port_sel, done});
    end
    @(posedge clk); #1;
    checks++;
    if (mem[0] !== 64'd5) begin
      failures++;
      $display("FAIL reset_mid write_suppressed: mem[0]=%h, required %h", mem[0], 64'd5);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("reset_mid_after");
    init_vals[0] = 64'd5;
    run_sort("after_reset_count1", 1, 2, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sorted();
    test_short_counts();
    test_signed_boundary();
    test_equal_keys_restart();
    test_random();
    test_reset_midsort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
